// File: rtl/cart_header_pkg.sv
// Shared definitions for the cartridge header scanner: FSM states, MBC codes
// and the header byte addresses it reads.
package cart_header_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_NEXT,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] MBC_NONE  = 2'd0;
  localparam logic [1:0] MBC_1     = 2'd1;
  localparam logic [1:0] MBC_UNSUP = 2'd3;

  localparam logic [14:0] ADR_FIRST = 15'h0134;
  localparam logic [14:0] ADR_TYPE  = 15'h0147;
  localparam logic [14:0] ADR_ROM   = 15'h0148;
  localparam logic [14:0] ADR_RAM   = 15'h0149;
  localparam logic [14:0] ADR_CKS   = 15'h014D;

endpackage

// File: rtl/cart_header.sv
// Reads the cartridge header (0x0134..0x014D) one byte at a time, validates
// checksum, sizes and mapper type, and holds the system in reset until accepted.
module cart_header
  import cart_header_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rescan,
  output logic [14:0] rd_adr,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [2:0]  rom_size,
  output logic [1:0]  ram_size,
  output logic [1:0]  mbc_type,
  output logic        done,
  output logic        error,
  output logic        sys_reset
);

  state_e      state;
  logic [7:0]  cks;
  logic [7:0]  tmo_cnt;

  logic [1:0]  mbc_stg;
  logic [2:0]  rom_stg;
  logic        rom_bad;
  logic [1:0]  ram_stg;
  logic        ram_bad;
  logic [7:0]  hdr_cks;
  logic        hdr_ok;

  function automatic logic [1:0] mbc_decode(input logic [7:0] b);
    if (b == 8'h00)      return MBC_NONE;
    else if (b <= 8'h03) return MBC_1;
    else                 return MBC_UNSUP;
  endfunction

  // Codes 0 and 1 both mean "no RAM"; 2 and 3 pass straight through.
  function automatic logic [1:0] ram_decode(input logic [7:0] b);
    return b[1] ? b[1:0] : 2'd0;
  endfunction

  assign hdr_ok = (cks == hdr_cks) && !rom_bad && !ram_bad && (mbc_stg != MBC_UNSUP);

  // Field staging: not reset, every field is rewritten before CHECK on each scan
  always_ff @(posedge clk) begin
    if (state == ST_REQ && rd_ack) begin
      case (rd_adr)
        ADR_TYPE: mbc_stg <= mbc_decode(rd_data);
        ADR_ROM: begin
          rom_stg <= rd_data[2:0];
          rom_bad <= (rd_data > 8'h06);
        end
        ADR_RAM: begin
          ram_stg <= ram_decode(rd_data);
          ram_bad <= (rd_data > 8'h03);
        end
        ADR_CKS: hdr_cks <= rd_data;
        default: ;
      endcase
    end
  end

  // Scan FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rd_req    <= 1'b0;
      rd_adr    <= ADR_FIRST;
      cks       <= 8'h00;
      tmo_cnt   <= 8'h00;
      rom_size  <= 3'd0;
      ram_size  <= 2'd0;
      mbc_type  <= MBC_NONE;
      done      <= 1'b0;
      error     <= 1'b0;
      sys_reset <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_REQ;
          rd_req  <= 1'b1;
          rd_adr  <= ADR_FIRST;
          cks     <= 8'h00;
          tmo_cnt <= 8'h00;
        end
        ST_REQ: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= ST_NEXT;
            if (rd_adr < ADR_CKS) cks <= cks - rd_data - 8'd1;
          end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
            rd_req <= 1'b0;
            state  <= ST_ERROR;
            error  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_NEXT: begin
          if (rd_adr == ADR_CKS) begin
            state <= ST_CHECK;
          end else begin
            rd_adr  <= rd_adr + 15'd1;
            rd_req  <= 1'b1;
            tmo_cnt <= 8'h00;
            state   <= ST_REQ;
          end
        end
        ST_CHECK: begin
          if (hdr_ok) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            sys_reset <= 1'b0;
            rom_size  <= rom_stg;
            ram_size  <= ram_stg;
            mbc_type  <= mbc_stg;
          end else begin
            state <= ST_ERROR;
            error <= 1'b1;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (rescan) begin
            state     <= ST_REQ;
            rd_req    <= 1'b1;
            rd_adr    <= ADR_FIRST;
            cks       <= 8'h00;
            tmo_cnt   <= 8'h00;
            done      <= 1'b0;
            error     <= 1'b0;
            sys_reset <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cart_header.md
CART_HEADER -- requirements
Module: cart_header

Interface
REQ-001 TIMEOUT, 255, max cycles to wait for rd_ack per byte (1..255).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 rescan  in  1  single-cycle pulse; restart scan from DONE or ERROR (cartridge swap).
REQ-005 rd_adr  out  15  cartridge ROM byte address being read.
REQ-006 rd_req  out  1  read request; held with rd_adr stable until acknowledged.
REQ-007 rd_ack  in  1  read acknowledge; rd_data valid in the same cycle.
REQ-008 rd_data  in  8  cartridge ROM byte.
REQ-009 rom_size  out  3  ROM size code (header byte 0x148) for the mapper.
REQ-010 ram_size  out  2  RAM size code (header byte 0x149) for the mapper.
REQ-011 mbc_type  out  2  0 = none, 1 = MBC1, 3 = unsupported.
REQ-012 done  out  1  scan finished and header accepted.
REQ-013 error  out  1  scan finished and header rejected (checksum, size, type or timeout).
REQ-014 sys_reset  out  1  active-high reset for the mapper and CPU; held until done.

Function
REQ-015 The block SHALL read bytes 0x0134..0x014D (26 bytes) in ascending order, one outstanding request at a time.
REQ-016 The FSM SHALL have states IDLE, REQ, NEXT, CHECK, DONE, ERROR; IDLE->REQ on the first clock after reset release or on rescan in DONE/ERROR.
REQ-017 In REQ, rd_req=1; a cycle with rd_ack=1 SHALL capture rd_data and go to NEXT; rd_req SHALL be 0 in NEXT (one idle cycle between reads).
REQ-018 NEXT SHALL increment rd_adr and return to REQ, or go to CHECK after 0x014D.
REQ-019 Checksum SHALL be 8-bit, initialised to 0, updated x = x - byte - 1 (mod 256) for 0x0134..0x014C; CHECK compares x with byte 0x014D.
REQ-020 Byte 0x147: 0x00 -> mbc_type 0; 0x01..0x03 -> 1; anything else -> 3.
REQ-021 Byte 0x148: 0x00..0x06 -> rom_size = byte[2:0]; larger -> error.
REQ-022 Byte 0x149: 0x00 or 0x01 -> 0; 0x02 -> 2; 0x03 -> 3; larger -> error.
REQ-023 CHECK SHALL go to DONE only if checksum matches, sizes are valid and mbc_type != 3; otherwise ERROR; CHECK lasts exactly one cycle.
REQ-024 Captured fields SHALL be staged internally; rom_size, ram_size and mbc_type SHALL update only on entry to DONE and hold until the next DONE.
REQ-025 A timeout counter SHALL reset on each REQ entry; TIMEOUT cycles in REQ without rd_ack -> ERROR with rd_req dropped.
REQ-026 rd_ack outside REQ SHALL be ignored; rescan outside DONE/ERROR SHALL be ignored.
REQ-027 With rd_ack asserted in the first REQ cycle every time, reset release to done SHALL take 1 + 26*2 + 1 = 54 cycles.
REQ-028 done=1 only in DONE, error=1 only in ERROR; sys_reset=1 in every state except DONE.
REQ-029 rescan in DONE SHALL reassert sys_reset in the next cycle while retaining the previous size outputs until a new DONE.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, rd_req=0, rd_adr=0x0134, rom_size=0, ram_size=0, mbc_type=0, done=0, error=0, sys_reset=1, checksum and timeout counter 0.
REQ-031 Reset mid-scan SHALL abandon the scan; no partially captured field reaches the outputs.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, mbc_type codes, and header address constants (0x0134, 0x0147, 0x0148, 0x0149, 0x014D).
REQ-033 No sub-module; the read-handshake timeout counter is inline.

Verification
REQ-034 Valid MBC1 header (0x147=0x03, 0x148=0x05, 0x149=0x03, correct checksum), immediate ack -> done at cycle 54, rom_size=5, ram_size=3, mbc_type=1, sys_reset=0.
REQ-035 Same header, checksum byte +1 -> error=1, sys_reset=1, size outputs remain 0.
REQ-036 rd_ack delayed 7 cycles per byte -> rd_adr stable during every wait, done at cycle 1 + 26*9 + 1 = 236, same outputs as REQ-034.
REQ-037 rd_ack never asserted, TIMEOUT=255 -> error exactly 255 cycles after first rd_req, rd_req=0 afterwards.
REQ-038 0x147=0x19 (unsupported), or 0x148=0x07 -> error; then rescan with a valid no-MBC header -> done, mbc_type=0.
REQ-039 reset_n pulsed low at byte 0x140 -> outputs cleared immediately, clean rescan from 0x0134 after release.
